// File: rtl/exemem_sched_if.sv
// Client and memory-port signal bundle for the exemem access scheduler.
// The master side is the environment (clients plus memory); the slave side is the scheduler.
interface exemem_sched_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              c0_req, c1_req;
    logic              c0_we, c1_we;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_wdata, c1_wdata;
    logic              c0_ack, c1_ack;
    logic              c0_rvalid, c1_rvalid;
    logic [DATA_W-1:0] c0_rdata, c1_rdata;
    logic [ADDR_W-1:0] mem_addr1, mem_addr2;
    logic [DATA_W-1:0] mem_dataIn1, mem_dataIn2;
    logic              mem_we1, mem_we2;
    logic [DATA_W-1:0] mem_dataOut1, mem_dataOut2;

    modport master (
        output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
               mem_dataOut1, mem_dataOut2,
        input  c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
               mem_addr1, mem_addr2, mem_dataIn1, mem_dataIn2, mem_we1, mem_we2
    );

    modport slave (
        input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr, c0_wdata, c1_wdata,
               mem_dataOut1, mem_dataOut2,
        output c0_ack, c1_ack, c0_rvalid, c1_rvalid, c0_rdata, c1_rdata,
               mem_addr1, mem_addr2, mem_dataIn1, mem_dataIn2, mem_we1, mem_we2
    );
endinterface

// File: rtl/exemem_sched.sv
// Dual-port exemem access scheduler: post-reset clear, round-robin collision arbitration.
// Define EXEMEM_CLEAR_EN to compile in the clear sequence; otherwise reset goes straight to RUN.
module exemem_sched #(
    parameter int                ADDR_W      = 8,
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic           clk,
    input  logic           reset,
    output logic           busy,
    exemem_sched_if.slave  bus
);
    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-2:0] cnt;
    logic              run, conflict, prio;

`ifdef EXEMEM_CLEAR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= CLEAR;
            cnt   <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;   // wraps to 0 on the last clear write
            if (&cnt) state <= RUN;
        end
    end
`else
    assign state = RUN;
    assign cnt   = '0;
`endif

    assign run  = (state == RUN);
    assign busy = ~run;

    // Two reads of one address may share a cycle; anything involving a write may not.
    assign conflict = bus.c0_req & bus.c1_req & (bus.c0_addr == bus.c1_addr)
                    & (bus.c0_we | bus.c1_we);
    assign bus.c0_ack = run & bus.c0_req & (~conflict | ~prio);
    assign bus.c1_ack = run & bus.c1_req & (~conflict |  prio);

    always_comb begin
        bus.mem_addr1   = bus.c0_addr;
        bus.mem_addr2   = bus.c1_addr;
        bus.mem_dataIn1 = bus.c0_wdata;
        bus.mem_dataIn2 = bus.c1_wdata;
        bus.mem_we1     = bus.c0_we & bus.c0_ack;
        bus.mem_we2     = bus.c1_we & bus.c1_ack;
        if (!run) begin
            bus.mem_addr1   = {cnt, 1'b0};
            bus.mem_addr2   = {cnt, 1'b1};
            bus.mem_dataIn1 = CLEAR_VALUE;
            bus.mem_dataIn2 = CLEAR_VALUE;
            bus.mem_we1     = 1'b1;
            bus.mem_we2     = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio          <= 1'b0;
            bus.c0_rvalid <= 1'b0;
            bus.c1_rvalid <= 1'b0;
        end else begin
            bus.c0_rvalid <= bus.c0_ack & ~bus.c0_we;
            bus.c1_rvalid <= bus.c1_ack & ~bus.c1_we;
            if (run && conflict) prio <= ~prio;   // hand priority to the loser
        end
    end

    assign bus.c0_rdata = bus.mem_dataOut1;
    assign bus.c1_rdata = bus.mem_dataOut2;
endmodule

// File: tb/tb_exemem_sched.sv
// Directed bench for exemem_sched with a behavioural dual-port memory attached.
module tb_exemem_sched;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   tests = 0;
    int   fails = 0;
    int   n, bad;

    exemem_sched_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    exemem_sched #(.ADDR_W(8), .DATA_W(16), .CLEAR_VALUE(16'h0000)) dut (
        .clk(clk), .reset(reset), .busy(busy), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 16'hFFFF;
    always @(posedge clk) begin
        bus.mem_dataOut1 <= mem[bus.mem_addr1];
        bus.mem_dataOut2 <= mem[bus.mem_addr2];
        if (bus.mem_we1) mem[bus.mem_addr1] <= bus.mem_dataIn1;
        if (bus.mem_we2) mem[bus.mem_addr2] <= bus.mem_dataIn2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic drv(input logic r0, input logic w0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1);
        bus.c0_req = r0; bus.c0_we = w0; bus.c0_addr = a0; bus.c0_wdata = d0;
        bus.c1_req = r1; bus.c1_we = w1; bus.c1_addr = a1; bus.c1_wdata = d1;
        #1;
    endtask

    task automatic idle;
        drv(0, 0, 8'd0, 16'h0, 0, 0, 8'd0, 16'h0);
    endtask

    // Counts cycles until busy drops, recording any cycle that deviates from the clear pattern.
    task automatic clear_walk;
        n = 0; bad = 0;
        while (busy && n < 300) begin
            if (bus.mem_addr1 != 8'(2*n) || bus.mem_addr2 != 8'(2*n+1) || !bus.mem_we1 ||
                !bus.mem_we2 || bus.mem_dataIn1 != 16'h0 || bus.mem_dataIn2 != 16'h0 ||
                bus.c0_ack || bus.c1_ack) bad++;
            tick;
            n++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drv(0, 0, 8'd0, 16'h0, 0, 0, 8'd0, 16'h0);
        #1;
`ifdef EXEMEM_CLEAR_EN
        check("rst_busy", busy, 1);
        check("rst_we1", bus.mem_we1, 1);
        check("rst_addr2", bus.mem_addr2, 1);
`else
        check("rst_busy", busy, 0);
`endif
        check("rst_rv0", bus.c0_rvalid, 0);
        check("rst_rv1", bus.c1_rvalid, 0);
        tick; tick;
        reset = 1'b0;

`ifdef EXEMEM_CLEAR_EN
        clear_walk;
        check("clr_len", n, 128);
        check("clr_pattern", bad, 0);
        drv(1, 0, 8'd0, 16'h0, 1, 0, 8'd77, 16'h0);
        check("rd0_ack0", bus.c0_ack, 1);
        check("rd0_ack1", bus.c1_ack, 1);
        tick;
        check("rd0_rv0", bus.c0_rvalid, 1);
        check("rd0_data0", bus.c0_rdata, 16'h0);
        check("rd77_data1", bus.c1_rdata, 16'h0);
        drv(1, 0, 8'd255, 16'h0, 0, 0, 8'd0, 16'h0);
        tick;
        check("rd255_data", bus.c0_rdata, 16'h0);
`else
        tick;
        check("run_busy", busy, 0);
`endif
        idle; tick;

        // Independent writes, then cross reads
        drv(1, 1, 8'd1, 16'd69, 1, 1, 8'd3, 16'd21);
        check("wr_ack0", bus.c0_ack, 1);
        check("wr_ack1", bus.c1_ack, 1);
        tick;
        drv(1, 0, 8'd3, 16'h0, 1, 0, 8'd1, 16'h0);
        check("wr_no_rv", bus.c0_rvalid, 0);
        tick;
        check("x_rv0", bus.c0_rvalid, 1);
        check("x_rv1", bus.c1_rvalid, 1);
        check("x_data0", bus.c0_rdata, 16'd21);
        check("x_data1", bus.c1_rdata, 16'd69);
        idle; tick;
        check("rv_pulse", bus.c0_rvalid, 0);

        // Write/write collision on addr 5, then a repeat with swapped priority
        drv(1, 1, 8'd5, 16'hAAAA, 1, 1, 8'd5, 16'h5555);
        check("ww_ack0", bus.c0_ack, 1);
        check("ww_ack1", bus.c1_ack, 0);
        check("ww_we2", bus.mem_we2, 0);
        tick;
        drv(0, 0, 8'd0, 16'h0, 1, 1, 8'd5, 16'h5555);
        check("ww_retry1", bus.c1_ack, 1);
        tick;
        drv(1, 0, 8'd5, 16'h0, 0, 0, 8'd0, 16'h0);
        tick;
        check("ww_mem5", bus.c0_rdata, 16'h5555);
        drv(1, 1, 8'd5, 16'h1111, 1, 1, 8'd5, 16'h2222);
        check("ww2_ack0", bus.c0_ack, 0);
        check("ww2_ack1", bus.c1_ack, 1);
        tick;
        drv(1, 1, 8'd5, 16'h1111, 0, 0, 8'd0, 16'h0);
        check("ww2_retry0", bus.c0_ack, 1);
        tick;
        drv(0, 0, 8'd0, 16'h0, 1, 0, 8'd5, 16'h0);
        tick;
        check("ww2_mem5", bus.c1_rdata, 16'h1111);
        idle; tick;

        // Shared read of addr 9
        drv(1, 1, 8'd9, 16'h0909, 0, 0, 8'd0, 16'h0);
        tick;
        drv(1, 0, 8'd9, 16'h0, 1, 0, 8'd9, 16'h0);
        check("rr_ack0", bus.c0_ack, 1);
        check("rr_ack1", bus.c1_ack, 1);
        tick;
        check("rr_rv0", bus.c0_rvalid, 1);
        check("rr_rv1", bus.c1_rvalid, 1);
        check("rr_data0", bus.c0_rdata, 16'h0909);
        check("rr_data1", bus.c1_rdata, 16'h0909);
        idle; tick;

        // Write vs read on addr 7; prio is back at c0, so the read sees the new word
        drv(0, 0, 8'd0, 16'h0, 1, 1, 8'd7, 16'h7777);
        tick;
        drv(1, 1, 8'd7, 16'h1234, 1, 0, 8'd7, 16'h0);
        check("wr_ack0", bus.c0_ack, 1);
        check("wr_ack1", bus.c1_ack, 0);
        tick;
        drv(0, 0, 8'd0, 16'h0, 1, 0, 8'd7, 16'h0);
        check("wr_retry1", bus.c1_ack, 1);
        tick;
        check("wr_rv1", bus.c1_rvalid, 1);
        check("wr_data1", bus.c1_rdata, 16'h1234);
        idle; tick;

        // Reset mid-operation (and mid-clear when clearing is built in)
        reset = 1'b1; #1;
        check("rst2_rv1", bus.c1_rvalid, 0);
        tick;
        reset = 1'b0;
`ifdef EXEMEM_CLEAR_EN
        for (int i = 0; i < 60; i++) tick;
        check("midclr_busy", busy, 1);
        reset = 1'b1; #1;
        check("midclr_addr1", bus.mem_addr1, 0);
        tick;
        reset = 1'b0;
        drv(1, 0, 8'd0, 16'h0, 0, 0, 8'd0, 16'h0);
        clear_walk;
        check("reclr_len", n, 128);
        check("reclr_noack", bad, 0);
        check("reclr_ack", bus.c0_ack, 1);
        tick;
        check("reclr_data", bus.c0_rdata, 16'h0);
`else
        check("rst2_busy", busy, 0);
`endif
        idle; tick;
        // Priority left at c1 before reset must have returned to c0
        drv(1, 1, 8'd11, 16'h0001, 1, 1, 8'd11, 16'h0002);
        check("prio_rst0", bus.c0_ack, 1);
        check("prio_rst1", bus.c1_ack, 0);
        idle; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
